// File: rtl/riscky_pkg.sv
// Shared definitions for the riscky core front end: widths, reset PC, opcodes, fetch states.
package riscky_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // A redirect target is word-misaligned when either low address bit is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return |addr_lo;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter: reset load, sequential +4 advance, and word-aligned redirect load
// with a one-cycle misalignment flag.
module if_pc_reg #(
    parameter int unsigned     XLEN     = riscky_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscky_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);
    import riscky_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic            misaligned_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect && is_misaligned(target[1:0]);
            // Redirect wins over the sequential advance; low bits are forced to a word boundary.
            if (redirect) begin
                pc_q <= {target[XLEN-1:2], 2'b00};
            end else if (inc) begin
                pc_q <= pc_q + XLEN'(4);
            end
        end
    end

    assign pc         = pc_q;
    assign misaligned = misaligned_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, holds one instruction for decode,
// and redirects on PCSrc while discarding any wrong-path response.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = riscky_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscky_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic            misaligned
);
    import riscky_pkg::*;

    fetch_state_e    state_q;
    logic            drop_q;
    logic            req_valid_q;
    logic            instr_valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;

    logic [XLEN-1:0] pc;
    logic            req_fire;
    logic            rsp_accept;

    assign req_fire   = (state_q == S_REQ) && req_valid_q && imem_req_ready;
    // A response advances the PC only when it is kept for decode.
    assign rsp_accept = (state_q == S_WAIT) && imem_rsp_valid && !drop_q && !pc_src;

    if_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .inc        (rsp_accept),
        .redirect   (pc_src),
        .target     (pc_target),
        .pc         (pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_REQ;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                        // Redirect on the handshake cycle: imem already took the old address.
                        drop_q      <= pc_src;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q || pc_src) begin
                            drop_q      <= 1'b0;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            instr_q       <= imem_rsp_data;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end
                    end else if (pc_src) begin
                        drop_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect squashes the held word whether or not decode takes it.
                    if (pc_src || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                        req_valid_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b0;
                    drop_q      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = req_valid_q ? pc : '0;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign op             = instr_q[6:0];

endmodule
